// File: rtl/layer_sequencer.sv
// layer_sequencer: top-level layer sequencer for the CNN accelerator.
// The sequencer steps through NUM_BLOCKS blocks. Each block has
// CONVS_PER_BLOCK conv layers followed by one average-pool layer.
// After the blocks it runs one FC layer and then the JUDGE phase.
//
// State codes:
//   RESET = 0, IDLE = 1
//   block b, conv k = 2 + b*(CONVS_PER_BLOCK+1) + k
//   block b, pool   = 2 + b*(CONVS_PER_BLOCK+1) + CONVS_PER_BLOCK
//   FC = 2 + NUM_BLOCKS*(CONVS_PER_BLOCK+1), JUDGE = FC + 1
//
// Ports:
//   clk, reset (async, active-low)
//   PS_BRAM_busy        : PS is loading a frame (only used in RESET/IDLE)
//   Conv_done, Avg_done, FC_done, Judge_done, Judge_all_done : engine done pulses
//   state               : current state code
//   layer_start         : pulse on the first cycle of each conv/pool/FC state
//   block_idx, conv_idx : position within the schedule (0 when not applicable)
//   is_conv/is_pool/is_fc : decoded layer type
//   frame_count         : frames judged since reset (wraps)
//   timeout_err         : watchdog pulse
//
// Optional build macro LAYER_SEQ_WATCHDOG_EN: adds a per-layer watchdog of
// TIMEOUT_CYCLES. Without the macro, timeout_err is tied to 0.
module layer_sequencer #(
  parameter int unsigned NUM_BLOCKS      = 3,
  parameter int unsigned CONVS_PER_BLOCK = 2,
  parameter int unsigned STATE_DATAWIDTH = 5,
  parameter int unsigned FRAME_CNT_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PS_BRAM_busy,
  input  logic                       Conv_done,
  input  logic                       Avg_done,
  input  logic                       FC_done,
  input  logic                       Judge_done,
  input  logic                       Judge_all_done,
  output logic [STATE_DATAWIDTH-1:0] state,
  output logic                       layer_start,
  output logic [2:0]                 block_idx,
  output logic [1:0]                 conv_idx,
  output logic                       is_conv,
  output logic                       is_pool,
  output logic                       is_fc,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       timeout_err
);

  localparam int unsigned P       = CONVS_PER_BLOCK + 1;
  localparam int unsigned FC_CODE = 2 + NUM_BLOCKS * P;

  if (NUM_BLOCKS < 1 || NUM_BLOCKS > 7 || CONVS_PER_BLOCK < 1 || CONVS_PER_BLOCK > 4 ||
      TIMEOUT_CYCLES < 2 || FRAME_CNT_WIDTH < 1 ||
      (64'd1 << STATE_DATAWIDTH) <= 64'(FC_CODE + 1)) begin : g_param_check
    $error("layer_sequencer: parameter out of range");
  end

  // The state code is derived from a layer-type phase and the block/conv
  // counters. This lets the schedule scale with the parameters without
  // needing a per-code state list.
  typedef enum logic [2:0] {PH_RESET, PH_IDLE, PH_CONV, PH_POOL, PH_FC, PH_JUDGE} phase_t;

  phase_t                     phase, phase_nxt;
  logic [2:0]                 blk_nxt;
  logic [1:0]                 cnv_nxt;
  logic                       advance;
  logic                       frame_inc;
  logic                       wd_fire;
  logic [STATE_DATAWIDTH-1:0] state_nxt;
  logic                       layer_start_nxt;
  logic                       is_conv_nxt, is_pool_nxt, is_fc_nxt;
  int unsigned                code;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase       <= PH_RESET;
      state       <= '0;
      layer_start <= 1'b0;
      block_idx   <= '0;
      conv_idx    <= '0;
      is_conv     <= 1'b0;
      is_pool     <= 1'b0;
      is_fc       <= 1'b0;
      frame_count <= '0;
    end else begin
      phase       <= phase_nxt;
      state       <= state_nxt;
      layer_start <= layer_start_nxt;
      block_idx   <= blk_nxt;
      conv_idx    <= cnv_nxt;
      is_conv     <= is_conv_nxt;
      is_pool     <= is_pool_nxt;
      is_fc       <= is_fc_nxt;
      if (frame_inc) frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
    end
  end

  // Next-state logic
  always_comb begin
    phase_nxt = phase;
    blk_nxt   = block_idx;
    cnv_nxt   = conv_idx;
    advance   = 1'b0;
    frame_inc = 1'b0;
    case (phase)
      PH_RESET: if (PS_BRAM_busy) begin
        phase_nxt = PH_IDLE;
        advance   = 1'b1;
      end
      PH_IDLE: if (!PS_BRAM_busy) begin
        phase_nxt = PH_CONV;
        blk_nxt   = '0;
        cnv_nxt   = '0;
        advance   = 1'b1;
      end
      PH_CONV: if (Conv_done) begin
        advance = 1'b1;
        if (conv_idx == 2'(CONVS_PER_BLOCK - 1)) begin
          phase_nxt = PH_POOL;
          cnv_nxt   = '0;
        end else begin
          cnv_nxt = conv_idx + 2'd1;
        end
      end
      PH_POOL: if (Avg_done) begin
        advance = 1'b1;
        if (block_idx == 3'(NUM_BLOCKS - 1)) begin
          phase_nxt = PH_FC;
          blk_nxt   = '0;
        end else begin
          phase_nxt = PH_CONV;
          blk_nxt   = block_idx + 3'd1;
        end
      end
      PH_FC: if (FC_done) begin
        phase_nxt = PH_JUDGE;
        advance   = 1'b1;
      end
      PH_JUDGE: begin
        if (Judge_all_done) begin
          phase_nxt = PH_RESET;
          frame_inc = 1'b1;
        end else if (Judge_done) begin
          phase_nxt = PH_IDLE;
          frame_inc = 1'b1;
        end
      end
      default: phase_nxt = PH_RESET;
    endcase
    if (wd_fire) begin
      phase_nxt = PH_RESET;
      blk_nxt   = '0;
      cnv_nxt   = '0;
      advance   = 1'b0;
    end
  end

  // Output logic: the outputs are computed from the next state, so the
  // registered outputs change on the same edge as the transition.
  always_comb begin
    code        = 0;
    is_conv_nxt = 1'b0;
    is_pool_nxt = 1'b0;
    is_fc_nxt   = 1'b0;
    case (phase_nxt)
      PH_IDLE:  code = 1;
      PH_CONV: begin
        code        = 2 + 32'(blk_nxt) * P + 32'(cnv_nxt);
        is_conv_nxt = 1'b1;
      end
      PH_POOL: begin
        code        = 2 + 32'(blk_nxt) * P + CONVS_PER_BLOCK;
        is_pool_nxt = 1'b1;
      end
      PH_FC: begin
        code      = FC_CODE;
        is_fc_nxt = 1'b1;
      end
      PH_JUDGE: code = FC_CODE + 1;
      default:  code = 0;
    endcase
    state_nxt       = STATE_DATAWIDTH'(code);
    layer_start_nxt = advance & (is_conv_nxt | is_pool_nxt | is_fc_nxt);
  end

`ifdef LAYER_SEQ_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        compute;
  logic        match_done;

  // The matching done is decoded directly (not taken from advance), so
  // wd_fire does not form a loop through the next-state logic.
  always_comb begin
    compute    = phase inside {PH_CONV, PH_POOL, PH_FC};
    match_done = (phase == PH_CONV && Conv_done) ||
                 (phase == PH_POOL && Avg_done)  ||
                 (phase == PH_FC   && FC_done);
    wd_fire    = compute && !match_done && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire;
      if (advance || wd_fire || !compute) wd_cnt <= '0;
      else                                wd_cnt <= wd_cnt + 32'd1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;
  localparam int TMO = 16;
`ifdef LAYER_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  // stimulus bit order: {busy, conv, avg, fc, judge, judge_all}
  localparam logic [5:0] I_B = 6'b100000, I_C = 6'b010000, I_A = 6'b001000,
                         I_F = 6'b000100, I_J = 6'b000010, I_JA = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy = 1'b0, cd = 1'b0, ad = 1'b0, fd = 1'b0, jd = 1'b0, ja = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] stA, stB;
  logic lsA, lsB, icA, ipA, ifA, icB, ipB, ifB, toA, toB;
  logic [2:0] bA, bB;
  logic [1:0] cA, cB;
  logic [7:0] fcA, fcB;

  layer_sequencer #(.NUM_BLOCKS(3), .CONVS_PER_BLOCK(2), .STATE_DATAWIDTH(5),
                    .FRAME_CNT_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .reset(reset), .PS_BRAM_busy(busy), .Conv_done(cd), .Avg_done(ad),
    .FC_done(fd), .Judge_done(jd), .Judge_all_done(ja), .state(stA), .layer_start(lsA),
    .block_idx(bA), .conv_idx(cA), .is_conv(icA), .is_pool(ipA), .is_fc(ifA),
    .frame_count(fcA), .timeout_err(toA));

  layer_sequencer #(.NUM_BLOCKS(2), .CONVS_PER_BLOCK(3), .STATE_DATAWIDTH(5),
                    .FRAME_CNT_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(clk), .reset(reset), .PS_BRAM_busy(busy), .Conv_done(cd), .Avg_done(ad),
    .FC_done(fd), .Judge_done(jd), .Judge_all_done(ja), .state(stB), .layer_start(lsB),
    .block_idx(bB), .conv_idx(cB), .is_conv(icB), .is_pool(ipB), .is_fc(ifB),
    .frame_count(fcB), .timeout_err(toB));

  wire [22:0] vecA = {stA, lsA, bA, cA, icA, ipA, ifA, fcA, toA};
  wire [22:0] vecB = {stB, lsB, bB, cB, icB, ipB, ifB, fcB, toB};

  int checks = 0;
  int errors = 0;

  // Reference model: the schedule is a flat list of layers, and the
  // position in that list gives the state code directly.
  // mode: 0 reset, 1 idle, 2 computing layer #pos, 3 judge
  typedef struct {
    int mode;
    int pos;
    int fc;
    bit ls;
    bit to;
    int wd;
  } mdl_t;

  mdl_t ma, mb;

  // 0 conv, 1 pool, 2 fc
  function automatic int kind_of(int pos, int nb, int cpb);
    if (pos == nb * (cpb + 1)) return 2;
    if (pos % (cpb + 1) == cpb) return 1;
    return 0;
  endfunction

  function automatic mdl_t step(mdl_t m, int nb, int cpb, logic [5:0] in);
    mdl_t n;
    int k;
    bit done;
    n = m;
    n.ls = 1'b0;
    n.to = 1'b0;
    case (m.mode)
      0: if (in[5]) n.mode = 1;
      1: if (!in[5]) begin n.mode = 2; n.pos = 0; n.ls = 1'b1; n.wd = 0; end
      2: begin
        k = kind_of(m.pos, nb, cpb);
        done = (k == 0) ? in[4] : (k == 1) ? in[3] : in[2];
        if (done) begin
          n.wd = 0;
          if (k == 2) n.mode = 3;
          else begin n.pos = m.pos + 1; n.ls = 1'b1; end
        end else if (WD && m.wd == TMO - 1) begin
          n.mode = 0; n.to = 1'b1; n.wd = 0;
        end else begin
          n.wd = m.wd + 1;
        end
      end
      default: if (in[0] || in[1]) begin
        n.mode = in[0] ? 0 : 1;
        n.fc = (m.fc + 1) % 256;
      end
    endcase
    return n;
  endfunction

  function automatic logic [22:0] exp_vec(mdl_t m, int nb, int cpb);
    int st, blk, cv, k;
    st = 0; blk = 0; cv = 0; k = -1;
    case (m.mode)
      1: st = 1;
      2: begin
        st = 2 + m.pos;
        k = kind_of(m.pos, nb, cpb);
        if (k != 2) blk = m.pos / (cpb + 1);
        if (k == 0) cv = m.pos % (cpb + 1);
      end
      3: st = 3 + nb * (cpb + 1);
      default: st = 0;
    endcase
    return {5'(st), m.ls, 3'(blk), 2'(cv), k == 0, k == 1, k == 2, 8'(m.fc), m.to};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= step(ma, 3, 2, {busy, cd, ad, fd, jd, ja});
      mb <= step(mb, 2, 3, {busy, cd, ad, fd, jd, ja});
    end
  end

  task automatic drive(input logic [5:0] v);
    {busy, cd, ad, fd, jd, ja} = v;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    {busy, cd, ad, fd, jd, ja} = 6'b111111;
    repeat (3) begin
      @(negedge clk);
      checks++; if (vecA !== 23'd0) begin errors++; $display("FAIL reset_a got %h want 0", vecA); end
      checks++; if (vecB !== 23'd0) begin errors++; $display("FAIL reset_b got %h want 0", vecB); end
    end
    {busy, cd, ad, fd, jd, ja} = 6'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(I_B);
    checks++; if (stA !== 5'd1) begin errors++; $display("FAIL reset_to_idle got %0d want 1", stA); end
    drive(6'b0);
    checks++;
    if ({stA, lsA, bA, cA} !== {5'd2, 1'b1, 3'd0, 2'd0}) begin
      errors++; $display("FAIL first_conv got st=%0d ls=%b b=%0d c=%0d want 2 1 0 0", stA, lsA, bA, cA);
    end
    checks++; if (vecB !== exp_vec(mb, 2, 3)) begin errors++; $display("FAIL first_conv_b got %h want %h", vecB, exp_vec(mb, 2, 3)); end
  endtask

  task automatic test_frame_walk();
    logic [5:0] seq [10];
    seq = '{I_C, I_C, I_A, I_C, I_C, I_A, I_C, I_C, I_A, I_F};
    for (int i = 0; i < 10; i++) begin
      drive(seq[i]);
      checks++; if (stA !== 5'(3 + i)) begin errors++; $display("FAIL walk_state step %0d got %0d want %0d", i, stA, 3 + i); end
      checks++; if (vecA !== exp_vec(ma, 3, 2)) begin errors++; $display("FAIL walk_a got %h want %h", vecA, exp_vec(ma, 3, 2)); end
      checks++; if (vecB !== exp_vec(mb, 2, 3)) begin errors++; $display("FAIL walk_b got %h want %h", vecB, exp_vec(mb, 2, 3)); end
    end
    drive(I_J);
    checks++;
    if ({stA, fcA} !== {5'd1, 8'd1}) begin
      errors++; $display("FAIL walk_judge got st=%0d fc=%0d want 1 1", stA, fcA);
    end
    drive(6'b0);
    checks++; if (vecA !== exp_vec(ma, 3, 2)) begin errors++; $display("FAIL walk_restart got %h want %h", vecA, exp_vec(ma, 3, 2)); end
  endtask

  task automatic test_wrong_type();
    logic [5:0] seq [7];
    logic [4:0] want [7];
    seq  = '{I_C, I_A, I_F, I_A | I_F | I_J, I_C, I_C | I_A | I_F, I_B};
    want = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd4, 5'd5, 5'd5};
    for (int i = 0; i < 7; i++) begin
      drive(seq[i]);
      checks++; if (stA !== want[i]) begin errors++; $display("FAIL wrong_type step %0d got %0d want %0d", i, stA, want[i]); end
      checks++; if (vecA !== exp_vec(ma, 3, 2)) begin errors++; $display("FAIL wrong_type_a got %h want %h", vecA, exp_vec(ma, 3, 2)); end
      checks++; if (vecB !== exp_vec(mb, 2, 3)) begin errors++; $display("FAIL wrong_type_b got %h want %h", vecB, exp_vec(mb, 2, 3)); end
      if (i == 4) begin
        checks++; if (ipA !== 1'b1) begin errors++; $display("FAIL pool_flag got %b want 1", ipA); end
      end
    end
    checks++; if ({bA, cA} !== {3'd1, 2'd0}) begin errors++; $display("FAIL block1_idx got b=%0d c=%0d want 1 0", bA, cA); end
  endtask

  task automatic test_judge_priority();
    int f0;
    int n;
    n = 0;
    while (ma.mode != 3 && n < 20) begin
      case (kind_of(ma.pos, 3, 2))
        0: drive(I_C);
        1: drive(I_A);
        default: drive(I_F);
      endcase
      n++;
      checks++; if (vecA !== exp_vec(ma, 3, 2)) begin errors++; $display("FAIL to_judge_a got %h want %h", vecA, exp_vec(ma, 3, 2)); end
    end
    checks++; if (stA !== 5'd12) begin errors++; $display("FAIL reach_judge got %0d want 12", stA); end
    f0 = ma.fc;
    drive(I_J | I_JA);
    checks++;
    if ({stA, fcA} !== {5'd0, 8'((f0 + 1) % 256)}) begin
      errors++; $display("FAIL judge_priority got st=%0d fc=%0d want 0 %0d", stA, fcA, (f0 + 1) % 256);
    end
    checks++; if (vecB !== exp_vec(mb, 2, 3)) begin errors++; $display("FAIL judge_b got %h want %h", vecB, exp_vec(mb, 2, 3)); end
  endtask

  task automatic test_hold_watchdog();
    logic [5:0] want;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(I_B); drive(6'b0); drive(I_C); drive(I_C); drive(I_A);
    checks++; if (stA !== 5'd5) begin errors++; $display("FAIL hold_entry got %0d want 5", stA); end
    for (int i = 1; i <= 40; i++) begin
      drive(6'b0);
      if (!WD)      want = {5'd5, 1'b0};
      else if (i < 16)  want = {5'd5, 1'b0};
      else if (i == 16) want = {5'd0, 1'b1};
      else              want = {5'd0, 1'b0};
      checks++; if ({stA, toA} !== want) begin errors++; $display("FAIL hold cyc %0d got st=%0d to=%b want %h", i, stA, toA, want); end
      checks++; if (vecB !== exp_vec(mb, 2, 3)) begin errors++; $display("FAIL hold_b got %h want %h", vecB, exp_vec(mb, 2, 3)); end
    end
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(I_B);
    checks++; if (stA !== 5'd1) begin errors++; $display("FAIL wrap_idle got %0d want 1", stA); end
    {busy, cd, ad, fd, jd, ja} = I_C | I_A | I_F | I_J;
    for (int n = 1; n <= 256 * 12; n++) begin
      @(negedge clk);
      checks++; if (vecA !== exp_vec(ma, 3, 2)) begin errors++; $display("FAIL wrap_a cyc %0d got %h want %h", n, vecA, exp_vec(ma, 3, 2)); end
      checks++; if (vecB !== exp_vec(mb, 2, 3)) begin errors++; $display("FAIL wrap_b cyc %0d got %h want %h", n, vecB, exp_vec(mb, 2, 3)); end
      if (n == 255 * 12) begin
        checks++; if ({stA, fcA} !== {5'd1, 8'd255}) begin errors++; $display("FAIL wrap_255 got st=%0d fc=%0d want 1 255", stA, fcA); end
      end
      if (n == 256 * 12) begin
        checks++; if ({stA, fcA} !== {5'd1, 8'd0}) begin errors++; $display("FAIL wrap_0 got st=%0d fc=%0d want 1 0", stA, fcA); end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        #1;
        checks++; if (vecA !== 23'd0) begin errors++; $display("FAIL async_reset got %h want 0", vecA); end
        @(negedge clk);
        reset = 1'b1;
      end else begin
        busy = 1'($urandom_range(0, 1));
        cd   = ($urandom_range(0, 2) == 0);
        ad   = ($urandom_range(0, 2) == 0);
        fd   = ($urandom_range(0, 2) == 0);
        jd   = ($urandom_range(0, 2) == 0);
        ja   = ($urandom_range(0, 7) == 0);
        @(negedge clk);
        checks++; if (vecA !== exp_vec(ma, 3, 2)) begin errors++; $display("FAIL rand_a cyc %0d got %h want %h", n, vecA, exp_vec(ma, 3, 2)); end
        checks++; if (vecB !== exp_vec(mb, 2, 3)) begin errors++; $display("FAIL rand_b cyc %0d got %h want %h", n, vecB, exp_vec(mb, 2, 3)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_walk();
    test_wrong_type();
    test_judge_priority();
    test_hold_watchdog();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
